// File: rtl/param_cu_pkg.sv
// Shared opcodes, FSM state encoding and bus-2 mux codes for the multicycle controller.
package param_cu_pkg;

    localparam int unsigned OP_NOP  = 0;
    localparam int unsigned OP_ADD  = 1;
    localparam int unsigned OP_SUB  = 2;
    localparam int unsigned OP_AND  = 3;
    localparam int unsigned OP_NOT  = 4;
    localparam int unsigned OP_RD   = 5;
    localparam int unsigned OP_WR   = 6;
    localparam int unsigned OP_BR   = 7;
    localparam int unsigned OP_BRZ  = 8;
    localparam int unsigned OP_OR   = 9;
    localparam int unsigned OP_XOR  = 10;
    localparam int unsigned OP_BRNZ = 11;
    localparam int unsigned OP_HALT = 15;

    typedef enum logic [3:0] {
        StIdle,
        StFet1,
        StFet2,
        StDec,
        StEx1,
        StRd1,
        StRd2,
        StWr1,
        StWr2,
        StBr1,
        StBr2,
        StHalt,
        StErr
    } cu_state_e;

    localparam logic [1:0] SEL2_ALU  = 2'd0;
    localparam logic [1:0] SEL2_BUS1 = 2'd1;
    localparam logic [1:0] SEL2_MEM  = 2'd2;
    localparam logic [1:0] SEL2_NONE = 2'd3;

endpackage

// File: rtl/cu_reg_decode.sv
// Register-address to one-hot load decoder; all zeros when disabled.
module cu_reg_decode #(
    parameter int unsigned REG_ADDR = 2
) (
    input  logic [REG_ADDR-1:0]      i_addr,
    input  logic                     i_en,
    output logic [2**REG_ADDR-1:0]   o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_addr] = 1'b1;
        end
    end

endmodule

// File: rtl/param_control_unit.sv
// Multicycle controller: sequences fetch/decode/execute/memory/branch phases for the bus datapath.
module param_control_unit
    import param_cu_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned OP_SIZE   = 4,
    parameter int unsigned REG_ADDR  = 2,
    localparam int unsigned NUM_REGS = 2**REG_ADDR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] instruction,
    input  logic                 zero,
    input  logic                 mem_ready,
    input  logic                 resume,
    output logic [NUM_REGS-1:0]  load_reg,
    output logic                 load_pc,
    output logic                 inc_pc,
    output logic                 load_ir,
    output logic                 load_add_r,
    output logic                 load_reg_y,
    output logic                 load_reg_z,
    output logic                 write,
    output logic [REG_ADDR:0]    sel_bus_1_mux,
    output logic [1:0]           sel_bus_2_mux,
    output logic [OP_SIZE-1:0]   alu_op,
    output logic                 halted,
    output logic                 err
);

    localparam logic [REG_ADDR:0] SEL1_PC = (REG_ADDR+1)'(NUM_REGS);

    cu_state_e            r_state;
    cu_state_e            w_state_next;
    logic                 r_err;
    logic [OP_SIZE-1:0]   w_opcode;
    logic [31:0]          w_op;
    logic [REG_ADDR-1:0]  w_src;
    logic [REG_ADDR-1:0]  w_dest;
    logic                 w_load_en;
    logic                 w_take;

    assign w_opcode = instruction[WORD_SIZE-1 -: OP_SIZE];
    assign w_op     = 32'(w_opcode);
    assign w_src    = instruction[2*REG_ADDR-1:REG_ADDR];
    assign w_dest   = instruction[REG_ADDR-1:0];
    assign w_take   = ((w_op == OP_BRZ) && zero) || ((w_op == OP_BRNZ) && !zero);

    assign alu_op = w_opcode;
    assign halted = (r_state == StHalt);
    assign err    = r_err;

    always_comb begin
        w_state_next  = r_state;
        w_load_en     = 1'b0;
        load_pc       = 1'b0;
        inc_pc        = 1'b0;
        load_ir       = 1'b0;
        load_add_r    = 1'b0;
        load_reg_y    = 1'b0;
        load_reg_z    = 1'b0;
        write         = 1'b0;
        sel_bus_1_mux = SEL1_PC;
        sel_bus_2_mux = SEL2_NONE;

        case (r_state)
            StIdle: w_state_next = StFet1;
            StFet1: begin
                sel_bus_2_mux = SEL2_BUS1;
                load_add_r    = 1'b1;
                w_state_next  = StFet2;
            end
            StFet2: begin
                sel_bus_2_mux = SEL2_MEM;
                if (mem_ready) begin
                    load_ir      = 1'b1;
                    inc_pc       = 1'b1;
                    w_state_next = StDec;
                end
            end
            StDec: begin
                case (w_op)
                    OP_NOP: w_state_next = StFet1;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        sel_bus_1_mux = {1'b0, w_src};
                        sel_bus_2_mux = SEL2_BUS1;
                        load_reg_y    = 1'b1;
                        w_state_next  = StEx1;
                    end
                    OP_NOT: begin
                        sel_bus_1_mux = {1'b0, w_src};
                        sel_bus_2_mux = SEL2_ALU;
                        load_reg_z    = 1'b1;
                        w_load_en     = 1'b1;
                        w_state_next  = StFet1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        sel_bus_2_mux = SEL2_BUS1;
                        load_add_r    = 1'b1;
                        w_state_next  = (w_op == OP_RD) ? StRd1 :
                                        (w_op == OP_WR) ? StWr1 : StBr1;
                    end
                    OP_BRZ, OP_BRNZ: begin
                        // Untaken conditional branch skips the operand word.
                        if (w_take) begin
                            sel_bus_2_mux = SEL2_BUS1;
                            load_add_r    = 1'b1;
                            w_state_next  = StBr1;
                        end else begin
                            inc_pc       = 1'b1;
                            w_state_next = StFet1;
                        end
                    end
                    OP_HALT: w_state_next = StHalt;
                    default: w_state_next = StErr;
                endcase
            end
            StEx1: begin
                sel_bus_1_mux = {1'b0, w_dest};
                sel_bus_2_mux = SEL2_ALU;
                load_reg_z    = 1'b1;
                w_load_en     = 1'b1;
                w_state_next  = StFet1;
            end
            StRd1, StWr1, StBr1: begin
                sel_bus_2_mux = SEL2_MEM;
                if (mem_ready) begin
                    load_add_r   = 1'b1;
                    inc_pc       = (r_state != StBr1);
                    w_state_next = (r_state == StRd1) ? StRd2 :
                                   (r_state == StWr1) ? StWr2 : StBr2;
                end
            end
            StRd2: begin
                sel_bus_2_mux = SEL2_MEM;
                if (mem_ready) begin
                    w_load_en    = 1'b1;
                    w_state_next = StFet1;
                end
            end
            StWr2: begin
                sel_bus_1_mux = {1'b0, w_src};
                sel_bus_2_mux = SEL2_BUS1;
                write         = 1'b1;
                if (mem_ready) begin
                    w_state_next = StFet1;
                end
            end
            StBr2: begin
                sel_bus_2_mux = SEL2_MEM;
                if (mem_ready) begin
                    load_pc      = 1'b1;
                    w_state_next = StFet1;
                end
            end
            StHalt: begin
                if (resume) begin
                    w_state_next = StFet1;
                end
            end
            StErr:   w_state_next = StErr;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == StErr) begin
                r_err <= 1'b1;
            end
        end
    end

    cu_reg_decode #(
        .REG_ADDR(REG_ADDR)
    ) u_reg_decode (
        .i_addr   (w_dest),
        .i_en     (w_load_en),
        .o_onehot (load_reg)
    );

endmodule

// File: tb/tb_param_control_unit.sv
// Directed scoreboard bench: expected control words queued per cycle, popped at the falling edge.
module tb_param_control_unit;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    localparam logic [8:0] S_PC  = 9'h100;
    localparam logic [8:0] S_INC = 9'h080;
    localparam logic [8:0] S_IR  = 9'h040;
    localparam logic [8:0] S_AR  = 9'h020;
    localparam logic [8:0] S_Y   = 9'h010;
    localparam logic [8:0] S_Z   = 9'h008;
    localparam logic [8:0] S_WR  = 9'h004;
    localparam logic [8:0] S_HL  = 9'h002;
    localparam logic [8:0] S_ER  = 9'h001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       rst, zero, mem_ready, resume;
    logic [7:0] instruction;
    logic [3:0] load_reg;
    logic       load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write;
    logic [2:0] sel1;
    logic [1:0] sel2;
    logic [3:0] alu_op;
    logic       halted, err;

    // REG_ADDR = 3, WORD_SIZE = 10 instance
    logic       rst3, mr3;
    logic [9:0] instr3;
    logic [7:0] load_reg3;
    logic       lpc3, inc3, lir3, lar3, ly3, lz3, write3, halted3, err3;
    logic [3:0] sel1_3;
    logic [1:0] sel2_3;
    logic [3:0] alu_op3;

    logic [31:0] obs, obs3;
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    param_control_unit dut (
        .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
        .mem_ready(mem_ready), .resume(resume), .load_reg(load_reg), .load_pc(load_pc),
        .inc_pc(inc_pc), .load_ir(load_ir), .load_add_r(load_add_r), .load_reg_y(load_reg_y),
        .load_reg_z(load_reg_z), .write(write), .sel_bus_1_mux(sel1), .sel_bus_2_mux(sel2),
        .alu_op(alu_op), .halted(halted), .err(err)
    );

    param_control_unit #(.WORD_SIZE(10), .OP_SIZE(4), .REG_ADDR(3)) dut3 (
        .clk(clk), .rst(rst3), .instruction(instr3), .zero(1'b0),
        .mem_ready(mr3), .resume(1'b0), .load_reg(load_reg3), .load_pc(lpc3),
        .inc_pc(inc3), .load_ir(lir3), .load_add_r(lar3), .load_reg_y(ly3),
        .load_reg_z(lz3), .write(write3), .sel_bus_1_mux(sel1_3), .sel_bus_2_mux(sel2_3),
        .alu_op(alu_op3), .halted(halted3), .err(err3)
    );

    assign obs  = {14'b0, load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z,
                   write, halted, err, load_reg, sel1, sel2};
    assign obs3 = {17'b0, write3, load_reg3, sel1_3, sel2_3};

    function automatic logic [31:0] e(input logic [8:0] s, input logic [3:0] lr,
                                      input logic [2:0] s1, input logic [1:0] s2);
        return {14'b0, s, lr, s1, s2};
    endfunction

    function automatic logic [31:0] e3(input logic wr, input logic [7:0] lr,
                                       input logic [3:0] s1, input logic [1:0] s2);
        return {17'b0, wr, lr, s1, s2};
    endfunction

    task automatic push(input string tag, input logic [31:0] v);
        exp_t x;
        x.tag = tag;
        x.val = v;
        sb.push_back(x);
    endtask

    task automatic sb_pop(input logic [31:0] o);
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed %h", o);
        end else begin
            x = sb.pop_front();
            assert (o === x.val) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", x.tag, o, x.val);
            end
        end
    endtask

    // Pop one expectation per cycle at the falling edge; leaves time at posedge+1.
    task automatic run(input int n, input bit use3 = 1'b0);
        repeat (n) begin
            @(negedge clk);
            sb_pop(use3 ? obs3 : obs);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fetch();
        push("fet1", e(S_AR, 4'b0, 3'd4, 2'd1));
        push("fet2", e(S_IR | S_INC, 4'b0, 3'd4, 2'd2));
    endtask

    initial begin
        rst = 1'b0; zero = 1'b0; mem_ready = 1'b1; resume = 1'b0; instruction = 8'h00;
        rst3 = 1'b0; mr3 = 1'b1; instr3 = 10'h1B8;
        @(posedge clk);
        #1;
        push("reset", e(9'h0, 4'b0, 3'd4, 2'd3));
        run(1);
        rst = 1'b1;

        // NOP
        push("idle", e(9'h0, 4'b0, 3'd4, 2'd3));
        fetch();
        push("nop_dec", e(9'h0, 4'b0, 3'd4, 2'd3));
        run(4);

        // ADD src=1 dest=2
        instruction = 8'h16;
        fetch();
        push("add_dec", e(S_Y, 4'b0, 3'd1, 2'd1));
        run(3);
        #1;
        push("add_alu_op", 32'd1);
        sb_pop(32'(alu_op));
        push("add_ex1", e(S_Z, 4'b0100, 3'd2, 2'd0));
        run(1);

        // RD dest=3 with two wait cycles in RD1
        instruction = 8'h53;
        fetch();
        push("rd_dec", e(S_AR, 4'b0, 3'd4, 2'd1));
        run(3);
        mem_ready = 1'b0;
        push("rd1_wait", e(9'h0, 4'b0, 3'd4, 2'd2));
        push("rd1_wait", e(9'h0, 4'b0, 3'd4, 2'd2));
        run(2);
        mem_ready = 1'b1;
        push("rd1", e(S_AR | S_INC, 4'b0, 3'd4, 2'd2));
        push("rd2", e(9'h0, 4'b1000, 3'd4, 2'd2));
        run(2);

        // BRZ untaken, BRNZ taken (zero = 0)
        instruction = 8'h80;
        fetch();
        push("brz_dec", e(S_INC, 4'b0, 3'd4, 2'd3));
        run(3);
        instruction = 8'hB0;
        fetch();
        push("brnz_dec", e(S_AR, 4'b0, 3'd4, 2'd1));
        push("brnz_br1", e(S_AR, 4'b0, 3'd4, 2'd2));
        push("brnz_br2", e(S_PC, 4'b0, 3'd4, 2'd2));
        run(5);

        // NOT src=1 dest=0; XOR src=3 dest=1
        instruction = 8'h44;
        fetch();
        push("not_dec", e(S_Z, 4'b0001, 3'd1, 2'd0));
        run(3);
        zero = 1'b1;
        instruction = 8'hAD;
        fetch();
        push("xor_dec", e(S_Y, 4'b0, 3'd3, 2'd1));
        push("xor_ex1", e(S_Z, 4'b0010, 3'd1, 2'd0));
        run(4);
        zero = 1'b0;

        // WR src=2 with one wait cycle in WR2
        instruction = 8'h68;
        fetch();
        push("wr_dec", e(S_AR, 4'b0, 3'd4, 2'd1));
        push("wr1", e(S_AR | S_INC, 4'b0, 3'd4, 2'd2));
        run(4);
        mem_ready = 1'b0;
        push("wr2_wait", e(S_WR, 4'b0, 3'd2, 2'd1));
        run(1);
        mem_ready = 1'b1;
        push("wr2", e(S_WR, 4'b0, 3'd2, 2'd1));
        run(1);

        // HALT, then resume; resume stays high into the next fetch
        instruction = 8'hF0;
        fetch();
        push("halt_dec", e(9'h0, 4'b0, 3'd4, 2'd3));
        push("halt", e(S_HL, 4'b0, 3'd4, 2'd3));
        push("halt", e(S_HL, 4'b0, 3'd4, 2'd3));
        run(5);
        resume = 1'b1;
        push("halt_resume", e(S_HL, 4'b0, 3'd4, 2'd3));
        run(1);

        // Illegal opcode 13 -> sticky err
        instruction = 8'hD0;
        fetch();
        push("ill_dec", e(9'h0, 4'b0, 3'd4, 2'd3));
        run(3);
        resume = 1'b0;
        repeat (3) push("err_sticky", e(S_ER, 4'b0, 3'd4, 2'd3));
        run(3);
        rst = 1'b0;
        #1;
        push("rst_async", e(9'h0, 4'b0, 3'd4, 2'd3));
        sb_pop(obs);
        @(posedge clk);
        #1;
        rst = 1'b1;
        instruction = 8'h00;
        push("post_rst_idle", e(9'h0, 4'b0, 3'd4, 2'd3));
        fetch();
        run(3);

        // Wide instance: WR src=7
        rst3 = 1'b1;
        push("w3_idle", e3(1'b0, 8'h00, 4'd8, 2'd3));
        push("w3_fet1_pc", e3(1'b0, 8'h00, 4'd8, 2'd1));
        push("w3_fet2", e3(1'b0, 8'h00, 4'd8, 2'd2));
        push("w3_dec", e3(1'b0, 8'h00, 4'd8, 2'd1));
        push("w3_wr1", e3(1'b0, 8'h00, 4'd8, 2'd2));
        push("w3_wr2", e3(1'b1, 8'h00, 4'd7, 2'd1));
        run(6, 1'b1);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL sb_leftover observed %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
